// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller for the five-stage RISC-V pipeline: M/W forwarding, load-use stalls and a
// single-entry scoreboard for a multi-cycle execute unit. Define HAZARD_PERF_EN to add perf counters.
module hazard_scoreboard_unit #(
   parameter int REG_AW   = 5,
   parameter int RSRC_W   = 3,
   parameter int LOAD_SRC = 1,
   parameter int MC_LAT   = 4,   // legal range 2..15
   parameter int CNT_W    = 4    // must hold MC_LAT-1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegwriteM,
   input  logic              RegwriteW,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic [REG_AW-1:0] RdE,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] RdD,
   input  logic              RegwriteD,
   input  logic [RSRC_W-1:0] resultsrcE,
   input  logic              mcStartE,
   input  logic [1:0]        pcsrcE,
   input  logic              jalD,
   output logic [1:0]        forwardAE,
   output logic [1:0]        forwardBE,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              flushD,
   output logic              flushE,
   output logic              mcBusy,
   output logic [REG_AW-1:0] mcRd,
   output logic              mcDoneW
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       perfStall,
   output logic [31:0]       perfFlush
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } mc_state_e;

   localparam logic [RSRC_W-1:0] LOAD_SEL = RSRC_W'(LOAD_SRC);
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MC_LAT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   mc_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [REG_AW-1:0] mc_rd_q, mc_rd_d;

   logic redirect;
   logic lwstall;
   logic rawstall;
   logic structstall;
   logic mc_accept;

   // Operand forwarding: M has priority over W, and x0 is never forwarded.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      if (RegwriteM && (Rs1E != '0) && (Rs1E == RdM)) begin
         forwardAE = 2'b10;
      end else if (RegwriteW && (Rs1E != '0) && (Rs1E == RdW)) begin
         forwardAE = 2'b01;
      end
      if (RegwriteM && (Rs2E != '0) && (Rs2E == RdM)) begin
         forwardBE = 2'b10;
      end else if (RegwriteW && (Rs2E != '0) && (Rs2E == RdW)) begin
         forwardBE = 2'b01;
      end
   end

   assign redirect = (pcsrcE != 2'b00);

   assign lwstall = (resultsrcE == LOAD_SEL) && (RdE != '0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

   // The RdD term blocks a younger write to the pending register (WAW).
   assign rawstall = mcBusy && (mc_rd_q != '0) &&
                     ((Rs1D == mc_rd_q) || (Rs2D == mc_rd_q) ||
                      (RegwriteD && (RdD == mc_rd_q)));

   // In DONE the entry frees this cycle, so a new op can take it without stalling.
   assign structstall = (state_q == S_BUSY) && mcStartE;

   assign stallF = (lwstall || rawstall || structstall) && !redirect;
   assign stallD = stallF;
   assign stallE = structstall && !redirect;
   assign flushE = redirect || ((lwstall || rawstall) && !structstall);
   assign flushD = redirect || jalD;

   assign mc_accept = mcStartE && !redirect;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mc_rd_d = mc_rd_q;
      unique case (state_q)
         S_IDLE: begin
            if (mc_accept) begin
               state_d = S_BUSY;
               cnt_d   = CNT_LOAD;
               mc_rd_d = RdE;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (mc_accept) begin
               state_d = S_BUSY;
               cnt_d   = CNT_LOAD;
               mc_rd_d = RdE;
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mc_rd_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so all state updates see pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mc_rd_q <= mc_rd_d;
      end
   end

   assign mcBusy  = (state_q != S_IDLE);
   assign mcDoneW = (state_q == S_DONE);
   assign mcRd    = mc_rd_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (stallD && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if ((flushD || flushE) && (perf_flush_q != 32'hFFFF_FFFF)) begin
            perf_flush_q <= perf_flush_q + 32'd1;
         end
      end
   end

   assign perfStall = perf_stall_q;
   assign perfFlush = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed scenarios plus randomized traffic
// against a cycle-age scoreboard model.
module tb_hazard_scoreboard_unit;

   localparam int REG_AW   = 5;
   localparam int RSRC_W   = 3;
   localparam int LOAD_SRC = 1;
   localparam int MC_LAT   = 4;
   localparam int CNT_W    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic RegwriteM, RegwriteW, RegwriteD, mcStartE, jalD;
   logic [REG_AW-1:0] RdM, RdW, RdE, Rs1E, Rs2E, Rs1D, Rs2D, RdD;
   logic [RSRC_W-1:0] resultsrcE;
   logic [1:0] pcsrcE;
   logic [1:0] forwardAE, forwardBE;
   logic stallF, stallD, stallE, flushD, flushE, mcBusy, mcDoneW;
   logic [REG_AW-1:0] mcRd;
`ifdef HAZARD_PERF_EN
   logic [31:0] perfStall, perfFlush;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_unit #(
      .REG_AW(REG_AW), .RSRC_W(RSRC_W), .LOAD_SRC(LOAD_SRC), .MC_LAT(MC_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .RegwriteM(RegwriteM), .RegwriteW(RegwriteW),
      .RdM(RdM), .RdW(RdW), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegwriteD(RegwriteD),
      .resultsrcE(resultsrcE), .mcStartE(mcStartE), .pcsrcE(pcsrcE), .jalD(jalD),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE),
      .flushD(flushD), .flushE(flushE),
      .mcBusy(mcBusy), .mcRd(mcRd), .mcDoneW(mcDoneW)
`ifdef HAZARD_PERF_EN
      , .perfStall(perfStall), .perfFlush(perfFlush)
`endif
   );

   // Reference scoreboard: an entry is valid with an age counted in cycles since its start;
   // it writes back when the age reaches MC_LAT.
   logic       m_valid;
   int         m_age;
   logic [4:0] m_rd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_age   <= 0;
         m_rd    <= '0;
      end else if (mcStartE && pcsrcE == 2'b00 && (!m_valid || m_age == MC_LAT)) begin
         m_valid <= 1'b1;
         m_age   <= 1;
         m_rd    <= RdE;
      end else if (m_valid && m_age == MC_LAT) begin
         m_valid <= 1'b0;
      end else if (m_valid) begin
         m_age <= m_age + 1;
      end
   end

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (rs != 0 && RegwriteM && rs == RdM) return 2'b10;
      if (rs != 0 && RegwriteW && rs == RdW) return 2'b01;
      return 2'b00;
   endfunction

   // {fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, busy, rd (when busy), done}
   function automatic logic [15:0] ref_outputs();
      logic done, lw, raw, st, redir, s_fd, s_e, f_d, f_e;
      done  = m_valid && (m_age == MC_LAT);
      redir = (pcsrcE != 0);
      lw    = (int'(resultsrcE) == LOAD_SRC) && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
      raw   = m_valid && m_rd != 0 && (Rs1D == m_rd || Rs2D == m_rd || (RegwriteD && RdD == m_rd));
      st    = m_valid && !done && mcStartE;
      s_fd  = (lw || raw || st) && !redir;
      s_e   = st && !redir;
      f_d   = redir || jalD;
      f_e   = redir || ((lw || raw) && !st);
      return {ref_fwd(Rs1E), ref_fwd(Rs2E), s_fd, s_fd, s_e, f_d, f_e,
              m_valid, (m_valid ? m_rd : 5'd0), done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      RegwriteM = 0; RegwriteW = 0; RegwriteD = 0; mcStartE = 0; jalD = 0;
      RdM = 0; RdW = 0; RdE = 0; Rs1E = 0; Rs2E = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
      resultsrcE = 0; pcsrcE = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #2;
      n_cmp++;
      if ({mcBusy, mcDoneW, mcRd} !== 7'b0) begin
         n_err++; $display("FAIL reset_state: got %b expected %b", {mcBusy, mcDoneW, mcRd}, 7'b0);
      end
      n_cmp++;
      if ({stallF, stallD, stallE, flushD, flushE} !== 5'b0) begin
         n_err++; $display("FAIL reset_ctrl: got %b expected %b", {stallF, stallD, stallE, flushD, flushE}, 5'b0);
      end
      RdM = 5; RegwriteM = 1; Rs1E = 5;
      #1;
      n_cmp++;
      if (forwardAE !== 2'b10) begin
         n_err++; $display("FAIL reset_comb_fwd: got %b expected %b", forwardAE, 2'b10);
      end
      tick();
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_forwarding();
      tick(); idle_inputs();
      RdM = 5; RegwriteM = 1; RdW = 5; RegwriteW = 1; Rs1E = 5; Rs2E = 5;
      #1;
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b1010) begin
         n_err++; $display("FAIL fwd_m_priority: got %b expected %b", {forwardAE, forwardBE}, 4'b1010);
      end
      RegwriteM = 0;
      #1;
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b0101) begin
         n_err++; $display("FAIL fwd_w: got %b expected %b", {forwardAE, forwardBE}, 4'b0101);
      end
      Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0; RegwriteM = 1;
      #1;
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b0000) begin
         n_err++; $display("FAIL fwd_x0: got %b expected %b", {forwardAE, forwardBE}, 4'b0000);
      end
      Rs1E = 4; Rs2E = 3; RdM = 4; RdW = 3; RegwriteW = 1;
      #1;
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b1001) begin
         n_err++; $display("FAIL fwd_split: got %b expected %b", {forwardAE, forwardBE}, 4'b1001);
      end
   endtask

   task automatic test_loaduse();
      tick(); idle_inputs();
      resultsrcE = LOAD_SRC; RdE = 7; Rs2D = 7;
      #1;
      n_cmp++;
      if ({stallF, stallD, stallE, flushD, flushE} !== 5'b11001) begin
         n_err++; $display("FAIL loaduse: got %b expected %b", {stallF, stallD, stallE, flushD, flushE}, 5'b11001);
      end
      tick();
      pcsrcE = 2'b01;
      #1;
      n_cmp++;
      if ({stallF, stallD, stallE, flushD, flushE} !== 5'b00011) begin
         n_err++; $display("FAIL loaduse_redirect: got %b expected %b", {stallF, stallD, stallE, flushD, flushE}, 5'b00011);
      end
      tick(); idle_inputs();
      resultsrcE = LOAD_SRC; RdE = 0; Rs1D = 0;
      #1;
      n_cmp++;
      if ({stallF, stallD, stallE, flushD, flushE} !== 5'b00000) begin
         n_err++; $display("FAIL loaduse_x0: got %b expected %b", {stallF, stallD, stallE, flushD, flushE}, 5'b00000);
      end
      jalD = 1;
      #1;
      n_cmp++;
      if ({stallF, stallD, stallE, flushD, flushE} !== 5'b00010) begin
         n_err++; $display("FAIL jal_flush: got %b expected %b", {stallF, stallD, stallE, flushD, flushE}, 5'b00010);
      end
   endtask

   // Start at cycle 0; busy for cycles 1..MC_LAT, done only at MC_LAT; redirect mid-flight ignored.
   task automatic test_mc_timing();
      tick(); idle_inputs();
      mcStartE = 1; RdE = 9;
      #1;
      n_cmp++;
      if (mcBusy !== 1'b0) begin
         n_err++; $display("FAIL mc_c0_busy: got %b expected %b", mcBusy, 1'b0);
      end
      for (int c = 1; c <= MC_LAT + 1; c++) begin
         tick(); idle_inputs();
         if (c == 2) Rs1D = 9;
         if (c == 3) pcsrcE = 2'b10;
         #1;
         n_cmp++;
         if ({mcBusy, mcDoneW} !== {1'(c <= MC_LAT), 1'(c == MC_LAT)}) begin
            n_err++; $display("FAIL mc_timing c%0d: got %b expected %b", c, {mcBusy, mcDoneW},
                              {1'(c <= MC_LAT), 1'(c == MC_LAT)});
         end
         if (c == 1) begin
            n_cmp++;
            if (mcRd !== 5'd9) begin
               n_err++; $display("FAIL mc_rd: got %0d expected %0d", mcRd, 9);
            end
         end
         if (c == 2) begin
            n_cmp++;
            if ({stallF, stallD, stallE, flushD, flushE} !== 5'b11001) begin
               n_err++; $display("FAIL mc_raw: got %b expected %b", {stallF, stallD, stallE, flushD, flushE}, 5'b11001);
            end
         end
      end
   endtask

   // Second start held by a structural stall, then accepted in the DONE cycle.
   task automatic test_struct();
      tick(); idle_inputs();
      mcStartE = 1; RdE = 9;
      for (int c = 1; c <= 2 * MC_LAT + 1; c++) begin
         logic exp_st;
         tick(); idle_inputs();
         mcStartE = (c >= 2 && c <= MC_LAT);
         RdE = 12;
         exp_st = (c >= 2 && c < MC_LAT);
         #1;
         n_cmp++;
         if ({stallF, stallD, stallE, mcBusy, mcDoneW} !==
             {exp_st, exp_st, exp_st, 1'(c <= 2 * MC_LAT), 1'(c == MC_LAT || c == 2 * MC_LAT)}) begin
            n_err++; $display("FAIL struct c%0d: got %b expected %b", c, {stallF, stallD, stallE, mcBusy, mcDoneW},
                              {exp_st, exp_st, exp_st, 1'(c <= 2 * MC_LAT), 1'(c == MC_LAT || c == 2 * MC_LAT)});
         end
         if (c == MC_LAT + 1) begin
            n_cmp++;
            if (mcRd !== 5'd12) begin
               n_err++; $display("FAIL struct_rd: got %0d expected %0d", mcRd, 12);
            end
         end
      end
   endtask

   // WAW stall, then asynchronous reset while BUSY: entry drops and never completes.
   task automatic test_waw_reset();
      tick(); idle_inputs();
      mcStartE = 1; RdE = 9;
      tick(); idle_inputs();
      RegwriteD = 1; RdD = 9;
      #1;
      n_cmp++;
      if ({stallF, stallD, stallE, flushD, flushE} !== 5'b11001) begin
         n_err++; $display("FAIL waw: got %b expected %b", {stallF, stallD, stallE, flushD, flushE}, 5'b11001);
      end
      RegwriteD = 0;
      #1;
      n_cmp++;
      if (stallD !== 1'b0) begin
         n_err++; $display("FAIL waw_nowrite: got %b expected %b", stallD, 1'b0);
      end
      tick(); idle_inputs();
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({mcBusy, mcDoneW, mcRd} !== 7'b0) begin
         n_err++; $display("FAIL rst_busy: got %b expected %b", {mcBusy, mcDoneW, mcRd}, 7'b0);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < MC_LAT + 2; c++) begin
         tick();
         n_cmp++;
         if ({mcBusy, mcDoneW} !== 2'b00) begin
            n_err++; $display("FAIL rst_no_done c%0d: got %b expected %b", c, {mcBusy, mcDoneW}, 2'b00);
         end
      end
   endtask

   // Start squashed by a same-cycle redirect; start with rd=x0 never raises a RAW stall.
   task automatic test_redirect_start();
      tick(); idle_inputs();
      mcStartE = 1; RdE = 6; pcsrcE = 2'b11;
      tick(); idle_inputs();
      #1;
      n_cmp++;
      if (mcBusy !== 1'b0) begin
         n_err++; $display("FAIL start_squashed: got %b expected %b", mcBusy, 1'b0);
      end
      mcStartE = 1; RdE = 0;
      tick(); idle_inputs();
      #1;
      n_cmp++;
      if ({mcBusy, stallD, flushE} !== 3'b100) begin
         n_err++; $display("FAIL mc_rd_x0: got %b expected %b", {mcBusy, stallD, flushE}, 3'b100);
      end
      repeat (MC_LAT) tick();
   endtask

   task automatic test_random();
      logic [15:0] exp_v, act_v;
      for (int i = 0; i < 600; i++) begin
         tick();
         RegwriteM  = 1'($urandom_range(0, 1));
         RegwriteW  = 1'($urandom_range(0, 1));
         RegwriteD  = 1'($urandom_range(0, 1));
         RdM  = 5'($urandom_range(0, 3)); RdW  = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdD  = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         resultsrcE = 3'($urandom_range(0, 2));
         mcStartE   = ($urandom_range(0, 3) == 0);
         pcsrcE     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         jalD       = ($urandom_range(0, 7) == 0);
         #1;
         exp_v = ref_outputs();
         act_v = {forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE,
                  mcBusy, (m_valid ? mcRd : 5'd0), mcDoneW};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_err++; $display("FAIL random i%0d: got %b expected %b", i, act_v, exp_v);
         end
      end
      tick(); idle_inputs();
      repeat (MC_LAT + 1) tick();
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      tick(); idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); idle_inputs();
         resultsrcE = LOAD_SRC; RdE = 7; Rs1D = 7;
         tick(); idle_inputs();
      end
      for (int i = 0; i < 2; i++) begin
         tick(); idle_inputs();
         pcsrcE = 2'b01;
         tick(); idle_inputs();
      end
      tick();
      n_cmp++;
      if (perfStall !== 32'd3) begin
         n_err++; $display("FAIL perf_stall: got %0d expected %0d", perfStall, 3);
      end
      n_cmp++;
      if (perfFlush !== 32'd5) begin
         n_err++; $display("FAIL perf_flush: got %0d expected %0d", perfFlush, 5);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_forwarding();
      test_loaduse();
      test_mc_timing();
      test_struct();
      test_waw_reset();
      test_redirect_start();
      test_random();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
